// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates icache and dcache requests onto a single RAM port,
// alternating on ties, with a granted-cycle watchdog and a sticky error flag.
module mem_arbiter #(
    parameter int WDOG = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);
    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;
    localparam logic [7:0] WLIM   = 8'(WDOG - 1);

    state_t      state, next_state;
    logic        last_d, next_last_d;
    logic [7:0]  wcnt, next_wcnt;
    logic        next_err;
    logic        i_pend, d_pend, cur_pend, pick_d, done, err;

    assign i_pend   = iREN;
    assign d_pend   = dREN | dWEN;
    assign cur_pend = (state == IGNT) ? i_pend : d_pend;
    assign done     = (state != IDLE) && (ramstate == ACCESS);
    assign err      = (state != IDLE) && (ramstate == ERROR);
    // On a tie, the requester that was not granted last time wins
    assign pick_d   = d_pend && (!i_pend || !last_d);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            last_d <= 1'b0;
            wcnt   <= 8'd0;
            memerr <= 1'b0;
        end else begin
            state  <= next_state;
            last_d <= next_last_d;
            wcnt   <= next_wcnt;
            memerr <= next_err;
        end
    end

    always_comb begin
        next_state  = state;
        next_last_d = last_d;
        next_wcnt   = wcnt;
        next_err    = memerr;
        if (state == IDLE || done) begin
            if (i_pend || d_pend) begin
                next_state  = pick_d ? DGNT : IGNT;
                next_last_d = pick_d;
                next_wcnt   = 8'd0;
            end else begin
                next_state = IDLE;
            end
        end else if (err) begin
            next_state = IDLE;
            next_err   = 1'b1;
        end else if (!cur_pend) begin
            next_state = IDLE;
        end else if (wcnt >= WLIM) begin
            next_state = IDLE;
            next_err   = 1'b1;
        end else begin
            next_wcnt = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
        end
    end

    assign ramREN   = (state == IGNT) ? iREN : (state == DGNT) ? (dREN & ~dWEN) : 1'b0;
    assign ramWEN   = (state == DGNT) & dWEN;
    assign ramaddr  = (state == IGNT) ? iaddr : (state == DGNT) ? daddr : 32'd0;
    assign ramstore = (state == DGNT) ? dstore : 32'd0;
    assign iwait    = !((state == IGNT) && done);
    assign dwait    = !((state == DGNT) && done);
    assign iload    = ramload;
    assign dload    = ramload;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, latency, watchdog, error and reset behaviour.
module tb_mem_arbiter;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, memerr;
    logic [31:0] iload, dload, ramaddr, ramstore;
    int checks = 0;
    int failures = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    mem_arbiter #(.WDOG(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 32'h1234; ramstate = FREE;
        #2;
        chk("rst_iwait", iwait, 1); chk("rst_dwait", dwait, 1);
        chk("rst_ramREN", ramREN, 0); chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0); chk("rst_memerr", memerr, 0);
        chk("iload_pass", iload, 32'h1234); chk("dload_pass", dload, 32'h1234);

        // icache read, RAM busy two cycles then access
        @(negedge CLK);
        nRST = 1; iREN = 1; iaddr = 32'h40; #1;
        chk("c0_ramREN", ramREN, 0);
        cyc(); ramstate = BUSY; #1;
        chk("c1_ramREN", ramREN, 1); chk("c1_ramaddr", ramaddr, 32'h40); chk("c1_iwait", iwait, 1);
        cyc(); #1;
        chk("c2_iwait", iwait, 1);
        cyc(); ramstate = ACCESS; ramload = 32'h8C010000; #1;
        chk("c3_iwait", iwait, 0); chk("c3_iload", iload, 32'h8C010000); chk("c3_dwait", dwait, 1);
        iREN = 0;
        cyc(); ramstate = FREE; #1;
        chk("c4_iwait", iwait, 1); chk("c4_ramREN", ramREN, 0);

        // simultaneous request after reset: dcache first, icache back-to-back
        nRST = 0; #1; nRST = 1;
        iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h3100; dstore = 32'hDEAD;
        cyc(); ramstate = ACCESS; #1;
        chk("tie_ramWEN", ramWEN, 1); chk("tie_ramREN", ramREN, 0);
        chk("tie_ramaddr", ramaddr, 32'h3100); chk("tie_ramstore", ramstore, 32'hDEAD);
        chk("tie_dwait", dwait, 0); chk("tie_iwait", iwait, 1);
        dWEN = 0;
        cyc(); #1;
        chk("b2b_ramREN", ramREN, 1); chk("b2b_ramaddr", ramaddr, 32'h80);
        chk("b2b_ramstore", ramstore, 0); chk("b2b_iwait", iwait, 0); chk("b2b_dwait", dwait, 1);
        iREN = 0;
        cyc(); #1;
        chk("b2b_idle", ramREN, 0);

        // both continuously requesting: D,I,D,I
        iREN = 1; dREN = 1;
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk($sformatf("alt%0d_dwait", k), dwait, (k % 2 == 0) ? 0 : 1);
            chk($sformatf("alt%0d_iwait", k), iwait, (k % 2 == 0) ? 1 : 0);
        end
        iREN = 0; dREN = 0;
        cyc(); #1;
        chk("alt_idle", iwait & dwait, 1);

        // write+read granted, then withdrawn before access
        dREN = 1; dWEN = 1; ramstate = BUSY;
        cyc(); #1;
        chk("wd_ramWEN", ramWEN, 1); chk("wd_ramREN", ramREN, 0); chk("wd_dwait", dwait, 1);
        dREN = 0; dWEN = 0;
        cyc(); #1;
        chk("wd_idle", ramWEN, 0); chk("wd_memerr", memerr, 0);

        // watchdog abort after four stalled granted cycles
        dREN = 1; daddr = 32'h500;
        for (int k = 1; k <= 4; k++) begin
            cyc(); #1;
            chk($sformatf("wdg%0d_ramREN", k), ramREN, 1);
            chk($sformatf("wdg%0d_dwait", k), dwait, 1);
            chk($sformatf("wdg%0d_memerr", k), memerr, 0);
        end
        cyc(); #1;
        chk("wdg_abort_ramREN", ramREN, 0); chk("wdg_abort_memerr", memerr, 1);
        chk("wdg_abort_dwait", dwait, 1);
        dREN = 0; iREN = 1; iaddr = 32'h44;
        cyc(); ramstate = ACCESS; ramload = 32'h55; #1;
        chk("wdg_after_iwait", iwait, 0); chk("wdg_after_ramaddr", ramaddr, 32'h44);
        chk("wdg_sticky", memerr, 1);
        iREN = 0;
        cyc(); #1;

        // RAM error during icache grant
        nRST = 0; #1; nRST = 1; #1;
        chk("err_rst_memerr", memerr, 0);
        iREN = 1; ramstate = BUSY;
        cyc(); ramstate = ERROR; #1;
        chk("err_iwait", iwait, 1); chk("err_ramREN", ramREN, 1);
        cyc(); #1;
        chk("err_idle", ramREN, 0); chk("err_memerr", memerr, 1); chk("err_iwait_idle", iwait, 1);
        iREN = 0;
        cyc(); #1;

        // reset pulse during a dcache grant
        nRST = 0; #1; nRST = 1;
        ramstate = BUSY; dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'hBEEF;
        cyc(); #1;
        chk("mid_ramWEN", ramWEN, 1); chk("mid_ramaddr", ramaddr, 32'h200);
        nRST = 0; #1;
        chk("mid_rst_ramWEN", ramWEN, 0); chk("mid_rst_ramREN", ramREN, 0);
        chk("mid_rst_ramaddr", ramaddr, 0); chk("mid_rst_ramstore", ramstore, 0);
        chk("mid_rst_waits", {iwait, dwait}, 2'b11); chk("mid_rst_memerr", memerr, 0);
        iREN = 1; dWEN = 0; dREN = 1; daddr = 32'h204;
        @(negedge CLK); nRST = 1;
        cyc(); ramstate = ACCESS; #1;
        chk("post_rst_dwait", dwait, 0); chk("post_rst_iwait", iwait, 1);
        chk("post_rst_ramaddr", ramaddr, 32'h204);
        iREN = 0; dREN = 0;
        cyc(); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
